// File: rtl/random_share_arbiter.sv
// Round-robin arbiter sharing one 23-bit Galois LFSR among several consumers.
// Each grant advances the LFSR STEPS times, so every consumer receives a fresh word.
module random_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int STEPS   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [23:1]        i_rng_data,
    output logic               o_rng_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_valid,
    output logic [23:1]        o_random_data,
    output logic               o_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [3:0] STEPS_LOAD = 4'(STEPS);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        CAPTURE,
        DELIVER
    } state_t;

    state_t             state_reg;
    logic [PTR_W-1:0]   ptr_reg;
    logic [PTR_W-1:0]   grant_idx_reg;
    logic [3:0]         count_reg;

    logic [NUM_REQ-1:0] hit;
    logic [PTR_W-1:0]   cand_idx [NUM_REQ];
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0]   ptr_next;

    // Offset gi looks at requester (ptr + gi) mod NUM_REQ, so hit[] is the
    // request vector rotated to start at the round-robin pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [PTR_W:0] sum;
        assign sum = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
        assign cand_idx[gi] = (sum >= NUM_REQ_W) ? PTR_W'(sum - NUM_REQ_W)
                                                 : sum[PTR_W-1:0];
        assign hit[gi] = i_req[cand_idx[gi]];
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[i];
            end
        end
    end

    assign pick_onehot = NUM_REQ'(1) << pick_idx;
    assign ptr_next    = (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_idx_reg <= '0;
            count_reg     <= '0;
            o_rng_enable  <= 1'b0;
            o_grant       <= '0;
            o_valid       <= 1'b0;
            o_random_data <= '0;
            o_busy        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        o_grant       <= pick_onehot;
                        grant_idx_reg <= pick_idx;
                        count_reg     <= STEPS_LOAD;
                        o_rng_enable  <= 1'b1;
                        o_busy        <= 1'b1;
                        state_reg     <= STEP;
                    end
                end
                STEP: begin
                    count_reg <= count_reg - 1'b1;
                    if (count_reg <= 4'd1) begin
                        o_rng_enable <= 1'b0;
                        state_reg    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // The last advance landed on the edge that entered this state.
                    o_random_data <= i_rng_data;
                    o_valid       <= 1'b1;
                    state_reg     <= DELIVER;
                end
                DELIVER: begin
                    o_valid   <= 1'b0;
                    o_grant   <= '0;
                    o_busy    <= 1'b0;
                    ptr_reg   <= ptr_next;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_random_share_arbiter.sv
// Bench for random_share_arbiter: two instances (STEPS=1 and STEPS=3) against
// a transaction-level model, with a queue-based scoreboard and directed scenarios.
module tb_random_share_arbiter;

    typedef struct packed {
        int          due;
        logic [3:0]  g;
        logic [23:1] d;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;

    int n_checks = 0;
    int n_errs   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int inst, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int ST = (gi == 0) ? 1 : 3;

        logic        en;
        logic        valid;
        logic        busy;
        logic [3:0]  grant;
        logic [23:1] data;
        logic [23:1] stub;

        random_share_arbiter #(
            .NUM_REQ(4),
            .STEPS  (ST)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_req        (req),
            .i_rng_data   (stub),
            .o_rng_enable (en),
            .o_grant      (grant),
            .o_valid      (valid),
            .o_random_data(data),
            .o_busy       (busy)
        );

        // LFSR stand-in: a counter that starts at 1 and steps when enabled.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) stub <= 23'd1;
            else if (en) stub <= stub + 23'd1;
        end

        exp_t        q[$];
        exp_t        e;
        int          edge_n  = 0;
        int          free_at = 0;
        int          cur_e   = 0;
        int          ptr     = 0;
        int          w       = 0;
        logic [3:0]  cur_g   = '0;
        logic [23:1] m_lfsr  = 23'd1;
        logic [23:1] last_d  = '0;
        bit          active  = 1'b0;

        // Model: a free arbiter grants at an edge, owns the LFSR for ST+2
        // cycles, and is free again ST+3 edges later.
        always @(posedge clk) begin
            edge_n++;
            if (!rst_n) begin
                q.delete();
                ptr     = 0;
                m_lfsr  = 23'd1;
                active  = 1'b0;
                cur_g   = '0;
                free_at = edge_n + 1;
            end else if (edge_n >= free_at && req != 4'd0) begin
                w       = pick(req, ptr);
                cur_e   = edge_n;
                cur_g   = 4'b0001 << w;
                m_lfsr  = m_lfsr + 23'(ST);
                q.push_back('{edge_n + ST + 1, cur_g, m_lfsr});
                ptr     = (w + 1) % 4;
                free_at = edge_n + ST + 3;
                active  = 1'b1;
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                check("rst_enable", gi, en, 0);
                check("rst_busy", gi, busy, 0);
                check("rst_grant", gi, grant, 0);
                check("rst_valid", gi, valid, 0);
                check("rst_data", gi, data, 0);
                last_d = '0;
            end else begin
                check("enable", gi, en, active && edge_n >= cur_e && edge_n < cur_e + ST);
                check("busy", gi, busy, active && edge_n <= cur_e + ST + 1);
                check("grant", gi, grant, (active && edge_n <= cur_e + ST + 1) ? cur_g : 4'd0);
                if (valid) begin
                    if (q.size() == 0) begin
                        check("valid_unexpected", gi, 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("valid_edge", gi, edge_n, e.due);
                        check("valid_grant", gi, grant, e.g);
                        check("valid_data", gi, data, e.d);
                        last_d = e.d;
                    end
                end else begin
                    check("data_hold", gi, data, last_d);
                    if (q.size() > 0 && q[0].due < edge_n) begin
                        check("valid_timeout", gi, edge_n, q[0].due);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic check_all_zero();
        check("async_rst_enable", 0, g_inst[0].en, 0);
        check("async_rst_grant", 0, g_inst[0].grant, 0);
        check("async_rst_busy", 0, g_inst[0].busy, 0);
        check("async_rst_data", 0, g_inst[0].data, 0);
        check("async_rst_enable", 1, g_inst[1].en, 0);
        check("async_rst_grant", 1, g_inst[1].grant, 0);
        check("async_rst_busy", 1, g_inst[1].busy, 0);
        check("async_rst_data", 1, g_inst[1].data, 0);
    endtask

    int lat0;
    int lat1;
    int cnt;
    bit found;

    initial begin
        rst_n = 1'b0;
        req   = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle: the LFSR must not move.
        repeat (50) @(negedge clk);
        check("idle_stub", 0, g_inst[0].stub, 1);
        check("idle_stub", 1, g_inst[1].stub, 1);

        // Single requester, measured latency and data.
        req  = 4'b0010;
        lat0 = 0;
        lat1 = 0;
        for (cnt = 1; cnt <= 10; cnt++) begin
            @(negedge clk);
            if (cnt == 1) req = 4'd0;
            if (g_inst[0].valid && lat0 == 0) begin
                lat0 = cnt;
                check("single_grant", 0, g_inst[0].grant, 4'b0010);
                check("single_data", 0, g_inst[0].data, 2);
            end
            if (g_inst[1].valid && lat1 == 0) begin
                lat1 = cnt;
                check("single_grant", 1, g_inst[1].grant, 4'b0010);
                check("single_data", 1, g_inst[1].data, 4);
            end
        end
        check("single_latency", 0, lat0, 3);
        check("single_latency", 1, lat1, 5);

        // All requesters held: rotation is covered by the scoreboard.
        req = 4'b1111;
        repeat (20) @(negedge clk);
        req = 4'd0;
        repeat (12) @(negedge clk);

        // Requester 2 withdraws while instance 0 is in CAPTURE.
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        req = 4'd0;
        repeat (12) @(negedge clk);

        // Move the pointer to 1, then reset in the middle of STEP.
        req = 4'b0001;
        @(negedge clk);
        req = 4'd0;
        repeat (10) @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (g_inst[0].valid) begin
                found = 1'b1;
                check("post_reset_grant", 0, g_inst[0].grant, 4'b0001);
            end
        end
        check("post_reset_valid_seen", 0, found, 1);
        req = 4'd0;
        repeat (12) @(negedge clk);

        // Randomised request traffic.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
        end
        req = 4'd0;
        repeat (20) @(negedge clk);
        check("drain", 0, g_inst[0].q.size(), 0);
        check("drain", 1, g_inst[1].q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
